// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq
//   Sequencer for the multi-cycle multiply/divide unit in the E stage.
//   It latches the operands of mult/multu/div/divu, counts down the busy
//   period and then commits the 64-bit result into HI/LO. It also serves
//   mthi/mtlo writes, mfhi/mflo reads and the single-cycle mul result, and
//   raises the D-stage stall while the unit is occupied.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   E_sel_MDU    in   E-stage op: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi,
//                     5 mflo, 6 mthi, 7 mtlo, 8 mul, any other code = none
//   E_A, E_B     in   forwarded rs / rt values
//   flush        in   cancels the E-stage op this cycle
//   D_instr_mdu  in   D-stage instruction touches the MDU
//   start        out  combinational: multi-cycle op accepted this cycle
//   busy         out  registered: multi-cycle op in progress
//   stall        out  D_instr_mdu & (start | busy)
//   HI, LO       out  architectural HI / LO registers
//   E_MDU_out    out  combinational: mfhi->HI, mflo->LO, mul->low product
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_sel_MDU,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        flush,
    input  logic        D_instr_mdu,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MDU_out
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;

    localparam logic [31:0] MULT_CNT = 32'(MULT_CYCLES);
    localparam logic [31:0] DIV_CNT  = 32'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        issue_ok_s;
    logic        mthi_s;
    logic        mtlo_s;
    logic [63:0] a_sx_s, b_sx_s;
    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] b_safe_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [31:0] mag_q_s, mag_r_s;
    logic [31:0] sdiv_q_s, sdiv_r_s;
    logic [31:0] udiv_q_s, udiv_r_s;

    // Issue qualification: idle and not flushed; start only for the multi-cycle ops.
    assign issue_ok_s = (flush == 1'b0) && (state_q == S_IDLE);
    assign start      = issue_ok_s && (E_sel_MDU <= OP_DIVU);
    assign mthi_s     = issue_ok_s && (E_sel_MDU == OP_MTHI);
    assign mtlo_s     = issue_ok_s && (E_sel_MDU == OP_MTLO);

    assign busy  = (state_q == S_BUSY);
    assign stall = D_instr_mdu && (start || busy);
    assign HI    = hi_q;
    assign LO    = lo_q;

    // Arithmetic on the latched operands; only sampled on the commit edge.
    // Signed product: low 64 bits of the sign-extended operands' product.
    assign a_sx_s   = {{32{a_q[31]}}, a_q};
    assign b_sx_s   = {{32{b_q[31]}}, b_q};
    assign prod_s_s = a_sx_s * b_sx_s;
    assign prod_u_s = {32'd0, a_q} * {32'd0, b_q};

    // Zero divisor is replaced so the dividers never see /0; the commit is skipped anyway.
    assign b_safe_s = (b_q == 32'd0) ? 32'd1 : b_q;

    // Signed divide via magnitudes: quotient sign = sign(a)^sign(b), remainder
    // takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_mag_s  = a_q[31] ? (32'd0 - a_q) : a_q;
    assign b_mag_s  = b_safe_s[31] ? (32'd0 - b_safe_s) : b_safe_s;
    assign mag_q_s  = a_mag_s / b_mag_s;
    assign mag_r_s  = a_mag_s % b_mag_s;
    assign sdiv_q_s = (a_q[31] ^ b_safe_s[31]) ? (32'd0 - mag_q_s) : mag_q_s;
    assign sdiv_r_s = a_q[31] ? (32'd0 - mag_r_s) : mag_r_s;
    assign udiv_q_s = a_q / b_safe_s;
    assign udiv_r_s = a_q % b_safe_s;

    // E-stage read path for the forwarding mux.
    always_comb begin
        E_MDU_out = 32'd0;
        case (E_sel_MDU)
            OP_MFHI: E_MDU_out = hi_q;
            OP_MFLO: E_MDU_out = lo_q;
            OP_MUL:  E_MDU_out = E_A * E_B;
            default: E_MDU_out = 32'd0;
        endcase
    end

    // Next-state logic: issue/latch while idle, count down and commit while busy.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = E_A;
                    b_d     = E_B;
                    op_d    = E_sel_MDU;
                    state_d = S_BUSY;
                    count_d = E_sel_MDU[1] ? DIV_CNT : MULT_CNT;
                end else if (mthi_s) begin
                    hi_d = E_A;
                end else if (mtlo_s) begin
                    lo_d = E_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (count_q == 32'd1) begin
                    state_d = S_IDLE;
                    count_d = 32'd0;
                    case (op_q)
                        OP_MULT: begin
                            hi_d = prod_s_s[63:32];
                            lo_d = prod_s_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_u_s[63:32];
                            lo_d = prod_u_s[31:0];
                        end
                        OP_DIV: begin
                            if (b_q != 32'd0) begin
                                hi_d = sdiv_r_s;
                                lo_d = sdiv_q_s;
                            end else begin
                                hi_d = hi_q;
                                lo_d = lo_q;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = udiv_r_s;
                                lo_d = udiv_q_s;
                            end else begin
                                hi_d = hi_q;
                                lo_d = lo_q;
                            end
                        end
                        default: begin
                            hi_d = hi_q;
                            lo_d = lo_q;
                        end
                    endcase
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 32'd0;
            end
        endcase
    end

    // State, operand and HI/LO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_NONE  = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_sel_MDU = OP_NONE;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        flush = 1'b0;
    logic        D_instr_mdu = 1'b0;
    logic        start, busy, stall;
    logic [31:0] HI, LO, E_MDU_out;

    mdu_seq #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .E_sel_MDU(E_sel_MDU), .E_A(E_A), .E_B(E_B),
        .flush(flush), .D_instr_mdu(D_instr_mdu), .start(start), .busy(busy),
        .stall(stall), .HI(HI), .LO(LO), .E_MDU_out(E_MDU_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural reference: whole 64-bit arithmetic, HI/LO kept on /0.
    function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] hi0,
                                    input logic [31:0] lo0);
        longint          sp;
        longint unsigned up;
        exp_t            r;
        r.hi  = hi0;
        r.lo  = lo0;
        r.cyc = (op < OP_DIV) ? MULT_CYCLES : DIV_CYCLES;
        case (op)
            OP_MULT: begin
                sp   = longint'($signed(a)) * longint'($signed(b));
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            OP_MULTU: begin
                up   = a;
                up   = up * b;
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    sp   = longint'($signed(a)) / longint'($signed(b));
                    r.lo = sp[31:0];
                    sp   = longint'($signed(a)) % longint'($signed(b));
                    r.hi = sp[31:0];
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: whenever busy falls, the next expected commit is popped and compared.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit actual=HI %h LO %h required=no commit", HI, LO);
            end else begin
                mon_e = sb.pop_front();
                chk("commit_hi", HI, mon_e.hi);
                chk("commit_lo", LO, mon_e.lo);
                chk("busy_cycles", busy_cnt, mon_e.cyc);
            end
            busy_cnt = 0;
        end
        if (reset === 1'b1) busy_cnt = 0;
    end

    // Follow the busy period to the cycle the result is visible; returns at that negedge.
    task automatic wait_idle(input logic dmdu);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            chk("stall_busy", stall, dmdu);
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=busy %b required=0 within 100 cycles", busy);
        end
        chk("stall_done", stall, 1'b0);
    endtask

    // mode 0: plain; 1: flush held during busy; 2: other ops presented while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmdu, input int mode);
        exp_t x;
        x = ref_op(op, a, b, model_hi, model_lo);
        sb.push_back(x);
        model_hi = x.hi;
        model_lo = x.lo;
        E_sel_MDU   = op;
        E_A         = a;
        E_B         = b;
        D_instr_mdu = dmdu;
        @(negedge clk);
        chk("start_issue", start, 1'b1);
        chk("stall_issue", stall, dmdu);
        tick();
        E_sel_MDU = OP_NONE;
        E_A = $urandom;
        E_B = $urandom;
        if (mode == 1) flush = 1'b1;
        if (mode == 2) begin
            E_sel_MDU = OP_MTHI;
            E_A = 32'hDEADBEEF;
            @(negedge clk);
            chk("start_busy_mt", start, 1'b0);
            tick();
            E_sel_MDU = op;
            @(negedge clk);
            chk("start_busy_op", start, 1'b0);
            tick();
            E_sel_MDU = OP_NONE;
        end
        wait_idle(dmdu);
        flush = 1'b0;
        E_sel_MDU = OP_MFHI;
        #1;
        chk("mfhi_after", E_MDU_out, model_hi);
        E_sel_MDU = OP_MFLO;
        #1;
        chk("mflo_after", E_MDU_out, model_lo);
        E_sel_MDU   = OP_NONE;
        D_instr_mdu = 1'b0;
        tick();
    endtask

    task automatic mt_op(input logic [3:0] op, input logic [31:0] v, input logic fl);
        E_sel_MDU = op;
        E_A       = v;
        flush     = fl;
        @(negedge clk);
        chk("start_mt", start, 1'b0);
        tick();
        E_sel_MDU = OP_NONE;
        flush     = 1'b0;
        if (!fl) begin
            if (op == OP_MTHI) model_hi = v;
            else model_lo = v;
        end
        @(negedge clk);
        chk("mt_hi", HI, model_hi);
        chk("mt_lo", LO, model_lo);
        chk("mt_busy", busy, 1'b0);
        tick();
    endtask

    task automatic mul_op(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        E_sel_MDU = OP_MUL;
        E_A = a;
        E_B = b;
        #1;
        chk("mul_out", E_MDU_out, p[31:0]);
        tick();
        E_sel_MDU = OP_NONE;
        @(negedge clk);
        chk("mul_hi", HI, model_hi);
        chk("mul_lo", LO, model_lo);
        tick();
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        // Reset state
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_start", start, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_out", E_MDU_out, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Directed arithmetic with stall observation
        run_op(OP_MULT,  32'hFFFFFFFE, 32'd3, 1'b1, 0);
        chk("mult_hi_dir", HI, 32'hFFFFFFFF);
        chk("mult_lo_dir", LO, 32'hFFFFFFFA);
        run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 0);
        chk("multu_hi_dir", HI, 32'h00000002);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 0);
        chk("div_lo_dir", LO, 32'hFFFFFFFD);
        chk("div_hi_dir", HI, 32'hFFFFFFFF);
        mt_op(OP_MTHI, 32'h11, 1'b0);
        mt_op(OP_MTLO, 32'h22, 1'b0);
        run_op(OP_DIVU, 32'd7, 32'd0, 1'b1, 0);
        chk("divu0_hi_dir", HI, 32'h11);
        chk("divu0_lo_dir", LO, 32'h22);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
        chk("div_ovf_lo", LO, 32'h80000000);
        chk("div_ovf_hi", HI, 32'h00000000);

        // Flushed issue: no start, no busy
        E_sel_MDU = OP_MULT; E_A = 32'd9; E_B = 32'd9; flush = 1'b1; D_instr_mdu = 1'b1;
        @(negedge clk);
        chk("flush_start", start, 1'b0);
        chk("flush_stall", stall, 1'b0);
        tick();
        E_sel_MDU = OP_NONE; flush = 1'b0; D_instr_mdu = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 1'b0);
        tick();
        mt_op(OP_MTHI, 32'h1234, 1'b1);
        mt_op(OP_MTLO, 32'hABCD, 1'b0);
        mul_op(32'hFFFFFFFF, 32'd5);

        // Flush during busy and ops presented while busy
        run_op(OP_MULT, $urandom, $urandom, 1'b1, 1);
        run_op(OP_DIV, $urandom, $urandom_range(100, 1), 1'b0, 2);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(3, 0));
            ra  = $urandom;
            rb  = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(3, 0) == 0) rb = 32'($urandom_range(16, 1));
            run_op(rop, ra, rb, 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)));
            if ($urandom_range(3, 0) == 0) mt_op($urandom_range(1, 0) ? OP_MTHI : OP_MTLO, $urandom, 1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) mul_op($urandom, $urandom);
        end

        // Reset mid-divide: abandoned, no later commit
        E_sel_MDU = OP_DIV; E_A = 32'd100; E_B = 32'd7;
        tick();
        E_sel_MDU = OP_NONE;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        @(negedge clk);
        chk("rstmid_late_hi", HI, 32'd0);
        chk("rstmid_late_lo", LO, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
